nibble_serial_add_ctrl: RTL and testbench

Sequencer that performs a WIDTH-bit addition by reusing one 4-bit carry-lookahead adder slice (S, Cout, PG, GG from A, B, Cin) over WIDTH/4 consecutive cycles. It processes one nibble per cycle, LSB first, and carries the slice Cout forward in a register. A start/busy/done handshake lets it be shared by the ALU datapath as an area-cheap wide adder.

---
 rtl/nibble_add_pkg.sv | 24 ++
 rtl/nibble_serial_add_ctrl_if.sv | 43 ++++
 rtl/nibble_serial_add_ctrl_cla4_slice.sv | 38 +++
 rtl/nibble_serial_add_ctrl.sv | 171 +++++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/nibble_add_pkg.sv
// nibble_add_pkg: shared constants, FSM state type and index-width helper
// for the nibble-serial adder.
package nibble_add_pkg;

   // Width of the single adder slice reused on every pass.
   localparam int NIBBLE_W = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Ceiling log2 with a floor of one bit, so a single-nibble build still
   // gets a legal index register.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: start/busy/done handshake plus operand and
// result bus. Optional group terms gp/gg appear when NIBBLE_ADD_GROUP_PG_EN
// is defined.
interface nibble_serial_add_ctrl_if #(
   parameter int WIDTH = 16
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

`ifdef NIBBLE_ADD_GROUP_PG_EN
   logic             gp;
   logic             gg;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf, gp, gg
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf, gp, gg
   );
`else
   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf
   );
`endif

endinterface

// File: rtl/nibble_serial_add_ctrl_cla4_slice.sv
// cla4_slice: purely combinational 4-bit carry-lookahead adder. It produces
// the sum nibble, carry-out and the slice group propagate/generate terms.
module cla4_slice
   import nibble_add_pkg::*;
(
   input  logic [NIBBLE_W-1:0] A,
   input  logic [NIBBLE_W-1:0] B,
   input  logic                Cin,
   output logic [NIBBLE_W-1:0] S,
   output logic                Cout,
   output logic                PG,
   output logic                GG
);

   logic [NIBBLE_W-1:0] w_p;
   logic [NIBBLE_W-1:0] w_g;
   logic [NIBBLE_W:0]   w_c;

   assign w_p = A ^ B;
   assign w_g = A & B;

   // Every carry is flattened from the bit-level terms, with no ripple.
   assign w_c[0] = Cin;
   assign w_c[1] = w_g[0] | (w_p[0] & Cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & Cin);

   assign PG = &w_p;
   assign GG = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

   assign w_c[4] = GG | (PG & Cin);

   assign S    = w_p ^ w_c[NIBBLE_W-1:0];
   assign Cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit adder built by running one 4-bit CLA
// slice over WIDTH/4 cycles, LSB nibble first. The slice carry is held in a
// register between passes. Results appear only at completion, together with
// a single-cycle done pulse.
// Optional macro NIBBLE_ADD_GROUP_PG_EN adds whole-word group
// propagate/generate outputs gp/gg.
module nibble_serial_add_ctrl
   import nibble_add_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic                          clk,
   input  logic                          rst,
   nibble_serial_add_ctrl_if.slave       bus
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   // Reject widths the slice cannot tile exactly.
   generate
      if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
         $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic                r_carry;
   logic [WIDTH-1:0]    r_a_lat;
   logic [WIDTH-1:0]    r_b_lat;
   logic [WIDTH-1:0]    r_work;
   logic                r_busy;
   logic                r_done;
   logic [WIDTH-1:0]    r_sum;
   logic                r_cout;
   logic                r_ovf;

   logic [NIBBLE_W-1:0] w_slice_a;
   logic [NIBBLE_W-1:0] w_slice_b;
   logic [NIBBLE_W-1:0] w_s;
   logic                w_cout;
   logic                w_pg;
   logic                w_gg;
   logic [WIDTH-1:0]    w_work_next;
   logic                w_carry_msb;

   // The current nibble of each latched operand feeds the shared slice.
   assign w_slice_a = r_a_lat[r_idx*NIBBLE_W +: NIBBLE_W];
   assign w_slice_b = r_b_lat[r_idx*NIBBLE_W +: NIBBLE_W];

   cla4_slice u_slice (
      .A    (w_slice_a),
      .B    (w_slice_b),
      .Cin  (r_carry),
      .S    (w_s),
      .Cout (w_cout),
      .PG   (w_pg),
      .GG   (w_gg)
   );

   // Work word with this pass's sum nibble merged in, so the completion edge
   // can publish the full result directly.
   always_comb begin
      // NOTE: assign a default before the partial update so every bit is
      // written on every path and no latch is inferred.
      w_work_next = r_work;
      w_work_next[r_idx*NIBBLE_W +: NIBBLE_W] = w_s;
   end

   // Carry into the MSB is recovered from the MSB sum bit and its operands.
   assign w_carry_msb = r_a_lat[WIDTH-1] ^ r_b_lat[WIDTH-1] ^ w_work_next[WIDTH-1];

`ifdef NIBBLE_ADD_GROUP_PG_EN
   logic r_gp_acc;
   logic r_gg_acc;
   logic r_gp;
   logic r_gg;
   logic w_gp_next;
   logic w_gg_next;

   // Fold this nibble's group terms into the running word-level terms.
   assign w_gp_next = r_gp_acc & w_pg;
   assign w_gg_next = w_gg | (w_pg & r_gg_acc);

   assign bus.gp = r_gp;
   assign bus.gg = r_gg;
`else
   // The slice group terms have no consumer without the group feature.
   logic w_unused_group;
   assign w_unused_group = w_pg ^ w_gg;
`endif

   // Control FSM and all datapath registers: accept in IDLE, one slice pass
   // per RUN cycle, and publish the result on the last pass.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before the edge.
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_a_lat <= '0;
         r_b_lat <= '0;
         r_work  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
`ifdef NIBBLE_ADD_GROUP_PG_EN
         r_gp_acc <= 1'b1;
         r_gg_acc <= 1'b0;
         r_gp     <= 1'b0;
         r_gg     <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a_lat <= bus.a;
                  r_b_lat <= bus.b;
                  r_carry <= bus.cin;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
`ifdef NIBBLE_ADD_GROUP_PG_EN
                  r_gp_acc <= 1'b1;
                  r_gg_acc <= 1'b0;
`endif
               end
            end
            RUN: begin
               r_work  <= w_work_next;
               r_carry <= w_cout;
               r_idx   <= r_idx + 1'b1;
`ifdef NIBBLE_ADD_GROUP_PG_EN
               r_gp_acc <= w_gp_next;
               r_gg_acc <= w_gg_next;
`endif
               if (r_idx == LAST_IDX) begin
                  r_sum   <= w_work_next;
                  r_cout  <= w_cout;
                  r_ovf   <= w_carry_msb ^ w_cout;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
`ifdef NIBBLE_ADD_GROUP_PG_EN
                  r_gp <= w_gp_next;
                  r_gg <= w_gg_next;
`endif
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
   assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: table vectors, hand-written corner sequences
// and random operations for the nibble-serial adder at WIDTH=16.
// Group terms are checked too when NIBBLE_ADD_GROUP_PG_EN is defined.
module tb_nibble_serial_add_ctrl;

   localparam int WIDTH = 16;

   logic clk;
   logic rst;

   int n_vec;
   int n_err;
   logic [WIDTH-1:0] exp_prev_sum;

   nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

   nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer addition, with signed overflow taken from the sign rules.
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic cin);
      logic [16:0] full;
      logic        ovf;
      full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      ovf  = (a[15] == b[15]) && (full[15] != a[15]);
      return {ovf, full};
   endfunction

   // One operation: launch it, scramble the inputs during RUN if asked, then
   // check busy, the latency, the held sum, the result and the one-cycle done.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input bit scramble);
      int lat;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = ta;
      bus.b     = tb_v;
      bus.cin   = tcin;
      @(negedge clk);
      bus.start = 1'b0;
      if (scramble) begin
         bus.a   = 16'($urandom);
         bus.b   = 16'($urandom);
         bus.cin = ~tcin;
      end
      lat = 0;
      while (bus.done !== 1'b1 && lat < 20) begin
         check("busy_in_run", {31'd0, bus.busy}, 32'd1);
         check("sum_held", {16'd0, bus.sum}, {16'd0, exp_prev_sum});
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 4);
      check("done", {31'd0, bus.done}, 32'd1);
      check("busy_at_done", {31'd0, bus.busy}, 32'd0);
      check("sum", {16'd0, bus.sum}, {16'd0, es});
      check("cout", {31'd0, bus.cout}, {31'd0, ec});
      check("ovf", {31'd0, bus.ovf}, {31'd0, eo});
`ifdef NIBBLE_ADD_GROUP_PG_EN
      begin
         logic [16:0] raw;
         raw = {1'b0, ta} + {1'b0, tb_v};
         check("gp", {31'd0, bus.gp}, {31'd0, ((ta ^ tb_v) == 16'hFFFF)});
         check("gg", {31'd0, bus.gg}, {31'd0, raw[16]});
      end
`endif
      exp_prev_sum = es;
      @(negedge clk);
      check("done_one_cycle", {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] m;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;

      n_vec = 0;
      n_err = 0;
      exp_prev_sum = '0;

      vecs[0] = '{16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'hD00D, 16'hA00A, 1'b1, 16'h7018, 1'b1, 1'b1};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[6] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
      vecs[7] = '{16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state.
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_sum", {16'd0, bus.sum}, 32'd0);
      check("rst_cout", {31'd0, bus.cout}, 32'd0);
      check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`ifdef NIBBLE_ADD_GROUP_PG_EN
      check("rst_gp", {31'd0, bus.gp}, 32'd0);
      check("rst_gg", {31'd0, bus.gg}, 32'd0);
`endif

      // Table vectors, with operands scrambled during RUN.
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1'b1);
      end

      // start held high: the done cycle is IDLE, so the next accept comes one
      // edge later and done recurs every NIBBLES+1 cycles with no truncation.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 16'h1111;
      bus.b     = 16'h2222;
      bus.cin   = 1'b0;
      @(negedge clk);
      for (int e = 0; e < 15; e++) begin
         check("cont_done", {31'd0, bus.done}, {31'd0, (e % 5) == 4});
         check("cont_busy", {31'd0, bus.busy}, {31'd0, (e % 5) != 4});
         if ((e % 5) == 4) begin
            check("cont_sum", {16'd0, bus.sum}, 32'h3333);
         end
         if (e == 13) begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      check("cont_idle_after", {31'd0, bus.busy}, 32'd0);
      exp_prev_sum = 16'h3333;

      // Reset during RUN cycle 2 aborts with no done pulse.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 16'h1234;
      bus.b     = 16'h4321;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_done", {31'd0, bus.done}, 32'd0);
      check("abort_sum", {16'd0, bus.sum}, 32'd0);
      check("abort_cout", {31'd0, bus.cout}, 32'd0);
      check("abort_ovf", {31'd0, bus.ovf}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("abort_no_done", {31'd0, bus.done}, 32'd0);
      end
      exp_prev_sum = '0;
      do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

      // Random operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         m  = model(ra, rb, rc);
         do_op(ra, rb, rc, m[15:0], m[16], m[17], 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
